pet2001ps2kbd: RTL and testbench
================================

// Module: pet2001ps2kbd
// PURPOSE
//  PS/2 keyboard front end for the PET I/O block. Deserialises raw PS/2 frames and decodes
//  make/break scancodes (E0/F0/E1 prefixes) into a 10x8 PET key matrix. Returns the
//  active-low column byte for the row the PIA1 drives on keyrow, feeding PIA1 port B (keyin).
// PARAMETERS
//  FILT_LEN    8      consecutive equal synced ps2_clk samples needed to change filtered level
//  TIMEOUT_CYC 65536  clk cycles with no falling edge before a partial frame is abandoned
// PORTS
//  clk       in   1  system clock; the only clock
//  reset     in   1  synchronous, active-high reset
//  ps2_clk   in   1  raw PS/2 clock (asynchronous)
//  ps2_data  in   1  raw PS/2 data (asynchronous)
//  keyrow    in   4  matrix row select from PIA1 port A[3:0]
//  keyin     out  8  active-low column bits of the selected row (1 = not pressed)
//  frame_err out  1  one-cycle pulse on a parity, start-bit or stop-bit error
// BEHAVIOUR
//  Input path: 2-FF synchroniser on ps2_clk and ps2_data. Filtered clk changes level only after
//   FILT_LEN equal samples. A falling edge of the filtered clk samples synced ps2_data.
//  Frame: start=0, 8 data bits LSB first, odd parity, stop=1. A 4-bit counter runs 0..10.
//   Bad start, parity or stop: byte discarded, frame_err pulses on the cycle after the stop
//   sample, counter returns to 0, and the prefix FSM returns to IDLE.
//  Watchdog: counter!=0 and TIMEOUT_CYC cycles with no filtered falling edge -> counter=0.
//   No error pulse is generated and the FSM is unchanged.
//  A good byte is presented to the FSM on the cycle after the stop sample. The matrix updates
//   on the following clk edge. Total latency is 2 clk from the filtered stop-bit falling edge.
//  Prefix FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
//   IDLE:    E0->EXT; F0->BRK; E1->PAUSE (skip count=7); AA/00/FF->clear matrix;
//            other codes -> press(map(code)).
//   EXT:     F0->EXT_BRK; 12/59 (fake shifts) ignored -> IDLE; other codes -> press(emap) -> IDLE.
//   BRK:     release(map(code)) -> IDLE.
//   EXT_BRK: release(emap(code)) -> IDLE.
//   PAUSE:   decrement skip count on each good byte; at 0 -> IDLE. Pause never maps to a key.
//  Mapping: combinational case table, PET graphics-keyboard layout. Unmapped codes are ignored.
//   Fixed entries: 1C(A)->r4b0, 12(LShift)->r8b0, 59(RShift)->r8b5, 5A(Enter)->r6b5,
//   29(Space)->r9b2, 66(Bksp)->r1b7 (DEL). E0 74(Right)->r0b7. E0 72(Down)->r1b6.
//  Matrix: 80 flops, reset to all 0 (released). Press sets the bit, release clears it.
//   Releasing a key that is not pressed is a no-op. A press and a release are never applied
//   in the same cycle because bytes are serial.
//  keyin = ~matrix[keyrow], combinational from registers (0-cycle from keyrow).
//   keyrow 10..15 -> 8'hFF.
//  Reset mid-frame or mid-prefix: counter=0, FSM=IDLE, matrix cleared, filters preset high,
//   frame_err=0.
// TESTING
//  1 Reset, keyrow=4 -> keyin=FF. Send 1C -> keyin=FE 2 clk after stop edge.
//    Send F0 1C -> keyin=FF.
//  2 Send 12 then 1C, keyrow=8 -> FE; keyrow=4 -> FE. Send F0 12 -> row8=FF, row4 stays FE.
//  3 Send E0 74, keyrow=0 -> 7F. Send E0 F0 74 -> FF. Send E0 12 -> every row FF.
//  4 Send 1C with the parity bit flipped -> frame_err pulses once, matrix unchanged.
//    Send F0, then a bad frame, then 1C -> r4b0 set (prefix was dropped).
//  5 Send 6 bits then idle TIMEOUT_CYC+1 cycles, then a full 1C frame -> r4b0 set,
//    no frame_err.
//  6 Press 1C and 29, send AA -> all rows FF. Send E1 14 77 E1 F0 14 F0 77 -> no change.
//    Glitch pulses on ps2_clk shorter than FILT_LEN -> no bit sampled.

Source files
------------

// File: rtl/pet2001ps2kbd.sv
// PS/2 keyboard front end for the PET: deserialises PS/2 frames, tracks make/break
// prefixes and keeps a 10x8 key matrix read back as an active-low column byte.
module pet2001ps2kbd #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  // Packs a matrix position as {valid, row, column}.
  function automatic logic [7:0] key(input logic [3:0] row, input logic [2:0] col);
    return {1'b1, row, col};
  endfunction

  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic [7:0] keymap(input logic [7:0] code);
    logic [7:0] m;
    case (code)
      8'h1C: m = key(4'd4, 3'd0);
      8'h32: m = key(4'd6, 3'd2);
      8'h21: m = key(4'd6, 3'd1);
      8'h23: m = key(4'd4, 3'd1);
      8'h24: m = key(4'd2, 3'd1);
      8'h2B: m = key(4'd5, 3'd1);
      8'h34: m = key(4'd4, 3'd2);
      8'h33: m = key(4'd5, 3'd2);
      8'h43: m = key(4'd3, 3'd3);
      8'h3B: m = key(4'd4, 3'd3);
      8'h42: m = key(4'd5, 3'd3);
      8'h4B: m = key(4'd4, 3'd4);
      8'h3A: m = key(4'd6, 3'd3);
      8'h31: m = key(4'd7, 3'd2);
      8'h44: m = key(4'd2, 3'd4);
      8'h4D: m = key(4'd3, 3'd4);
      8'h15: m = key(4'd2, 3'd0);
      8'h2D: m = key(4'd3, 3'd1);
      8'h1B: m = key(4'd5, 3'd0);
      8'h2C: m = key(4'd2, 3'd2);
      8'h3C: m = key(4'd2, 3'd3);
      8'h2A: m = key(4'd7, 3'd1);
      8'h1D: m = key(4'd3, 3'd0);
      8'h22: m = key(4'd7, 3'd0);
      8'h35: m = key(4'd3, 3'd2);
      8'h1A: m = key(4'd6, 3'd0);
      8'h16: m = key(4'd6, 3'd6);
      8'h1E: m = key(4'd7, 3'd6);
      8'h26: m = key(4'd6, 3'd7);
      8'h25: m = key(4'd4, 3'd6);
      8'h2E: m = key(4'd5, 3'd6);
      8'h36: m = key(4'd4, 3'd7);
      8'h3D: m = key(4'd2, 3'd6);
      8'h3E: m = key(4'd3, 3'd6);
      8'h46: m = key(4'd2, 3'd7);
      8'h45: m = key(4'd8, 3'd6);
      8'h4E: m = key(4'd8, 3'd7);
      8'h55: m = key(4'd9, 3'd7);
      8'h41: m = key(4'd7, 3'd3);
      8'h49: m = key(4'd9, 3'd6);
      8'h4A: m = key(4'd3, 3'd7);
      8'h4C: m = key(4'd6, 3'd4);
      8'h52: m = key(4'd5, 3'd4);
      8'h54: m = key(4'd9, 3'd1);
      8'h5B: m = key(4'd8, 3'd2);
      8'h5D: m = key(4'd1, 3'd3);
      8'h0E: m = key(4'd8, 3'd1);
      8'h12: m = key(4'd8, 3'd0);
      8'h59: m = key(4'd8, 3'd5);
      8'h5A: m = key(4'd6, 3'd5);
      8'h29: m = key(4'd9, 3'd2);
      8'h66: m = key(4'd1, 3'd7);
      8'h76: m = key(4'd9, 3'd4);
      8'h0D: m = key(4'd9, 3'd0);
      8'h7C: m = key(4'd5, 3'd7);
      8'h79: m = key(4'd7, 3'd7);
      8'h70: m = key(4'd8, 3'd6);
      8'h69: m = key(4'd6, 3'd6);
      8'h72: m = key(4'd7, 3'd6);
      8'h7A: m = key(4'd6, 3'd7);
      8'h6B: m = key(4'd4, 3'd6);
      8'h73: m = key(4'd5, 3'd6);
      8'h74: m = key(4'd4, 3'd7);
      8'h6C: m = key(4'd2, 3'd6);
      8'h75: m = key(4'd3, 3'd6);
      8'h7D: m = key(4'd2, 3'd7);
      8'h71: m = key(4'd9, 3'd6);
      // Function keys give the shifted-digit symbols that have their own PET keys
      8'h05: m = key(4'd0, 3'd0);
      8'h06: m = key(4'd1, 3'd0);
      8'h04: m = key(4'd0, 3'd1);
      8'h0C: m = key(4'd1, 3'd1);
      8'h03: m = key(4'd0, 3'd2);
      8'h0B: m = key(4'd0, 3'd3);
      8'h83: m = key(4'd1, 3'd2);
      8'h0A: m = key(4'd0, 3'd4);
      8'h01: m = key(4'd1, 3'd4);
      8'h09: m = key(4'd2, 3'd5);
      8'h78: m = key(4'd0, 3'd5);
      8'h07: m = key(4'd7, 3'd4);
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] ekeymap(input logic [7:0] code);
    logic [7:0] m;
    case (code)
      8'h74: m = key(4'd0, 3'd7);
      8'h72: m = key(4'd1, 3'd6);
      8'h6C: m = key(4'd0, 3'd6);
      8'h71: m = key(4'd1, 3'd7);
      8'h5A: m = key(4'd6, 3'd5);
      8'h4A: m = key(4'd3, 3'd7);
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_clk_r;
  logic          filt_prev_r;
  logic          fall_s;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic          start_bad_r;
  logic [TW-1:0] idle_cnt_r;
  logic          byte_valid_r;
  logic [7:0]    byte_r;
  logic          frame_err_r;
  state_t        state_r;
  logic [2:0]    skip_r;
  logic [7:0]    matrix_r [0:9];
  logic [7:0]    map_s;
  logic [7:0]    emap_s;

  // Two-stage synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Clock filter: the level flips only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_r  <= '0;
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r[1] == filt_clk_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_clk_r <= clk_sync_r[1];
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 1'b1;
      end
    end
  end

  assign fall_s = filt_prev_r & ~filt_clk_r;

  // Frame deserialiser with partial-frame watchdog; byte/error strobes last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      start_bad_r  <= 1'b0;
      idle_cnt_r   <= '0;
      byte_valid_r <= 1'b0;
      byte_r       <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_s) begin
        idle_cnt_r <= '0;
        case (bit_cnt_r)
          4'd0: begin
            start_bad_r <= data_sync_r[1];
            bit_cnt_r   <= 4'd1;
          end
          4'd9: begin
            parity_r  <= data_sync_r[1];
            bit_cnt_r <= 4'd10;
          end
          4'd10: begin
            if (!start_bad_r && parity_ok(shift_r, parity_r) && data_sync_r[1]) begin
              byte_r       <= shift_r;
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            bit_cnt_r <= 4'd0;
          end
          default: begin
            shift_r   <= {data_sync_r[1], shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        endcase
      end else if (bit_cnt_r == 4'd0) begin
        idle_cnt_r <= '0;
      end else if (idle_cnt_r == IDLE_LAST) begin
        bit_cnt_r  <= 4'd0;
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + 1'b1;
      end
    end
  end

  assign map_s  = keymap(byte_r);
  assign emap_s = ekeymap(byte_r);

  // Prefix FSM and key matrix; a bad frame abandons any pending prefix.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      skip_r  <= 3'd0;
      for (int r = 0; r < 10; r++) matrix_r[r] <= 8'h00;
    end else if (frame_err_r) begin
      state_r <= IDLE;
      skip_r  <= 3'd0;
    end else if (byte_valid_r) begin
      case (state_r)
        IDLE: begin
          case (byte_r)
            8'hE0: state_r <= EXT;
            8'hF0: state_r <= BRK;
            8'hE1: begin
              state_r <= PAUSE;
              skip_r  <= 3'd7;
            end
            8'hAA, 8'h00, 8'hFF: begin
              for (int r = 0; r < 10; r++) matrix_r[r] <= 8'h00;
            end
            default: begin
              if (map_s[7]) matrix_r[map_s[6:3]][map_s[2:0]] <= 1'b1;
            end
          endcase
        end
        EXT: begin
          if (byte_r == 8'hF0) begin
            state_r <= EXT_BRK;
          end else begin
            // 12/59 after E0 are the fake shifts some keyboards wrap around nav keys
            if (byte_r != 8'h12 && byte_r != 8'h59 && emap_s[7])
              matrix_r[emap_s[6:3]][emap_s[2:0]] <= 1'b1;
            state_r <= IDLE;
          end
        end
        BRK: begin
          if (map_s[7]) matrix_r[map_s[6:3]][map_s[2:0]] <= 1'b0;
          state_r <= IDLE;
        end
        EXT_BRK: begin
          if (emap_s[7]) matrix_r[emap_s[6:3]][emap_s[2:0]] <= 1'b0;
          state_r <= IDLE;
        end
        PAUSE: begin
          if (skip_r <= 3'd1) begin
            skip_r  <= 3'd0;
            state_r <= IDLE;
          end else begin
            skip_r <= skip_r - 3'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Row readback, active low; rows beyond the matrix read as no keys.
  always_comb begin
    keyin = 8'hFF;
    if (keyrow < 4'd10) begin
      keyin = ~matrix_r[keyrow];
    end else begin
      keyin = 8'hFF;
    end
  end

  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_pet2001ps2kbd.sv
// Self-checking bench for pet2001ps2kbd: directed scenarios plus random scancode streams
// compared against a flag-based keyboard model and a position table.
module tb_pet2001ps2kbd;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 16;
  localparam int GAP  = 8;
  localparam int LAT  = FILT + 4;
  localparam int NK   = 85;

  // {ext, code, row, column} per key
  localparam logic [19:0] KTAB [0:NK-1] = '{
    20'h01C40, 20'h03262, 20'h02161, 20'h02341, 20'h02421, 20'h02B51, 20'h03442, 20'h03352,
    20'h04333, 20'h03B43, 20'h04253, 20'h04B44, 20'h03A63, 20'h03172, 20'h04424, 20'h04D34,
    20'h01520, 20'h02D31, 20'h01B50, 20'h02C22, 20'h03C23, 20'h02A71, 20'h01D30, 20'h02270,
    20'h03532, 20'h01A60, 20'h01666, 20'h01E76, 20'h02667, 20'h02546, 20'h02E56, 20'h03647,
    20'h03D26, 20'h03E36, 20'h04627, 20'h04586, 20'h04E87, 20'h05597, 20'h04173, 20'h04996,
    20'h04A37, 20'h04C64, 20'h05254, 20'h05491, 20'h05B82, 20'h05D13, 20'h00E81, 20'h01280,
    20'h05985, 20'h05A65, 20'h02992, 20'h06617, 20'h07694, 20'h00D90, 20'h07C57, 20'h07977,
    20'h07086, 20'h06966, 20'h07276, 20'h07A67, 20'h06B46, 20'h07356, 20'h07447, 20'h06C26,
    20'h07536, 20'h07D27, 20'h07196, 20'h00500, 20'h00610, 20'h00401, 20'h00C11, 20'h00302,
    20'h00B03, 20'h08312, 20'h00A04, 20'h00114, 20'h00925, 20'h07805, 20'h00774, 20'h17407,
    20'h17216, 20'h16C06, 20'h17117, 20'h15A65, 20'h14A37
  };

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyrow;
  logic [7:0] keyin;
  logic       frame_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int err_cnt = 0;
  int exp_err = 0;

  // Keyboard model state
  logic [7:0] m_mat [0:9];
  bit m_ext, m_brk;
  int m_pause;

  pet2001ps2kbd #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyrow(keyrow), .keyin(keyin), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [7:0] code, input bit ext);
    for (int i = 0; i < NK; i++)
      if (KTAB[i][19:16] == {3'b000, ext} && KTAB[i][15:8] == code)
        return int'(KTAB[i][7:4]) * 8 + int'(KTAB[i][3:0]);
    return -1;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 10; r++) m_mat[r] = 8'h00;
  endtask

  task automatic m_set(input int pos, input logic v);
    if (pos >= 0) m_mat[pos / 8][pos % 8] = v;
  endtask

  task automatic model_byte(input logic [7:0] c);
    if (m_pause > 0) begin
      m_pause--;
    end else if (m_brk) begin
      m_set(lookup(c, m_ext), 1'b0);
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (c == 8'hF0) m_brk = 1;
      else begin
        if (c != 8'h12 && c != 8'h59) m_set(lookup(c, 1'b1), 1'b1);
        m_ext = 0;
      end
    end else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE1) m_pause = 7;
    else if (c == 8'hAA || c == 8'h00 || c == 8'hFF) m_clear();
    else m_set(lookup(c, 1'b0), 1'b1);
  endtask

  function automatic logic [7:0] exp_row(input int r);
    if (r >= 10) return 8'hFF;
    return ~m_mat[r];
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b0);
    model_byte(code);
  endtask

  task automatic send_bad(input logic [7:0] code);
    send_frame(code, 1'b1);
    m_ext = 0;
    m_brk = 0;
    m_pause = 0;
    exp_err++;
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      keyrow = 4'(r);
      #1;
      check(tag, {24'h0, keyin}, {24'h0, exp_row(r)});
    end
    check({tag, "_err"}, err_cnt, exp_err);
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] f;
    int sel;
    logic [7:0] c;

    m_clear();
    m_ext = 0; m_brk = 0; m_pause = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1; keyrow = 4'd4; reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    check_rows("reset");

    // 1: A press with exact latency from the raw stop-bit falling edge
    keyrow = 4'd4;
    f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat_before", {24'h0, keyin}, 32'hFF);
    @(posedge clk);
    #1 check("lat_after", {24'h0, keyin}, 32'hFE);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
    model_byte(8'h1C);
    check_rows("t1_press");
    send(8'hF0); send(8'h1C);
    check_rows("t1_release");

    // 2: shift plus A, release shift only
    send(8'h12); send(8'h1C);
    check_rows("t2_press");
    send(8'hF0); send(8'h12);
    check_rows("t2_rel_shift");
    send(8'hF0); send(8'h1C);

    // 3: extended cursor right, release, fake shift
    send(8'hE0); send(8'h74);
    @(negedge clk); keyrow = 4'd0; #1;
    check("t3_right", {24'h0, keyin}, 32'h7F);
    check_rows("t3_press");
    send(8'hE0); send(8'hF0); send(8'h74);
    check_rows("t3_release");
    send(8'hE0); send(8'h12);
    check_rows("t3_fake_shift");

    // 4: parity error, then a prefix dropped by a bad frame
    send_bad(8'h1C);
    check_rows("t4_parity");
    send(8'hF0); send_bad(8'h29); send(8'h1C);
    check_rows("t4_drop_prefix");
    send(8'hF0); send(8'h1C);

    // 5: partial frame abandoned by the watchdog
    f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 6; i++) ps2_bit(f[i]);
    repeat (TMO + 1) @(negedge clk);
    send(8'h1C);
    check_rows("t5_watchdog");

    // 6: clear-all, pause sequence, glitch rejection
    send(8'h29);
    check_rows("t6_two_keys");
    send(8'hAA);
    check_rows("t6_clear");
    send(8'h1C);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check_rows("t6_pause");
    send(8'h29);
    check_rows("t6_after_pause");
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (FILT - 5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    send(8'h5A);
    check_rows("t6_glitch");

    // Reset mid-prefix and mid-frame
    send(8'hE0);
    f = {1'b1, ~^8'h74, 8'h74, 1'b0};
    for (int i = 0; i < 4; i++) ps2_bit(f[i]);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_clear();
    m_ext = 0; m_brk = 0; m_pause = 0;
    #1 check("mid_rst_ferr", {31'h0, frame_err}, 32'h0);
    check_rows("mid_reset");
    send(8'h74);
    check_rows("after_reset");

    // Random scancode stream
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 19);
      c = KTAB[$urandom_range(0, NK - 1)][15:8];
      if (sel < 3) send(8'hE0);
      else if (sel < 6) send(8'hF0);
      else if (sel == 6) send(8'hAA);
      else if (sel == 7) send(8'hE1);
      else if (sel == 8) send_bad(c);
      else send(c);
      check_rows("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
